data_bus_if: RTL and testbench
==============================

// Module: data_bus_if
// PURPOSE
//  Data-side bus interface downstream of the MEM stage. Converts MEM's combinational RAM request
//  (ce/we/addr/sel/wdata) into a registered req/ack bus transaction with arbitrary wait states.
//  Holds the pipeline via stallreq_o until the access completes, then returns read data to MEM.
// PARAMETERS
//  ADDR_W          32   bus address width
//  DATA_W          32   bus data width (sel width = DATA_W/8)
//  TIMEOUT_CYCLES  255  BUSY cycles before forced abort (used only with DBUS_TIMEOUT_EN)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset: synchronous, active-high
//  ce_i         in   1          MEM request valid
//  we_i         in   1          1=write, 0=read
//  addr_i       in   ADDR_W     byte address from MEM
//  sel_i        in   DATA_W/8   byte enables from MEM
//  wdata_i      in   DATA_W     write data from MEM
//  stall_i      in   1          pipeline held by another stage this cycle
//  flush_i      in   1          pipeline flush (exception)
//  rdata_o      out  DATA_W     read data to MEM
//  stallreq_o   out  1          stall request to pipeline control
//  bus_req_o    out  1          bus request
//  bus_we_o     out  1          bus write enable
//  bus_addr_o   out  ADDR_W     bus address, word aligned ([1:0] forced 0)
//  bus_sel_o    out  DATA_W/8   bus byte enables
//  bus_wdata_o  out  DATA_W     bus write data
//  bus_ack_i    in   1          bus completion; read data valid in the same cycle
//  bus_rdata_i  in   DATA_W     bus read data
//  err_o        out  1          timeout pulse (constant 0 without DBUS_TIMEOUT_EN)
// BEHAVIOUR
//  - States: IDLE, BUSY, DONE, ABORT. Reset -> IDLE; all bus_* regs, rdata reg, err_o = 0.
//  - IDLE: ce_i=1 & !flush_i -> latch we/addr/sel/wdata; go BUSY; stallreq_o=1 combinationally.
//  - BUSY: bus_req_o=1; payload stable until ack. ack in first BUSY cycle is accepted.
//    - bus_ack_i -> capture bus_rdata_i (reads only; writes capture 0); drop req; go DONE.
//    - flush_i & !ack -> go ABORT.
//  - ABORT: keep req until ack, discard data, -> IDLE. stallreq_o = ce_i (new request waits).
//  - DONE: stallreq_o=0, rdata_o=captured data.
//    - stall_i=1 -> stay DONE. Else -> IDLE.
//    - flush_i -> IDLE.
//  - stallreq_o = (IDLE&ce_i&!flush_i) | BUSY | (ABORT&ce_i). rdata_o=0 outside DONE.
//  - Min latency: request cycle 0 (IDLE), ack cycle 1 (BUSY), data cycle 2 (DONE).
//    Pipeline stalled 2 cycles + wait states.
//  - ce_i=0 in IDLE: no bus activity; bus_req_o=0.
//  - Reset mid-transaction: bus_req_o drops the next edge; any late ack is ignored in IDLE.
//  - bus_ack_i outside BUSY/ABORT: ignored.
// CONFIGURATION
//  DBUS_TIMEOUT_EN defined:
//    - 8+ bit counter cleared on BUSY/ABORT entry, incremented each cycle without ack.
//    - Count == TIMEOUT_CYCLES: drop req, err_o=1 for one cycle, captured data=0,
//      then BUSY->DONE and ABORT->IDLE.
//  DBUS_TIMEOUT_EN undefined: no counter; waits indefinitely; err_o tied 0.
// TESTING
//  1 read addr=0x104 sel=1111, ack in 1st BUSY cycle, rdata=0xA5A5_1234
//    -> stallreq 2 cycles; rdata_o=0xA5A5_1234 in DONE.
//  2 write addr=0x203 sel=1000 wdata=0x7700_0000, ack after 3 waits
//    -> bus_addr_o=0x200, payload stable 4 cycles, 1 req per ack.
//  3 flush_i in 2nd BUSY cycle, ack 2 cycles later
//    -> ABORT, req held until ack, rdata_o never 0 -> data, returns IDLE.
//  4 ack then stall_i=1 for 2 cycles -> DONE held 3 cycles; rdata_o stable; no new req.
//  5 DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack
//    -> req dropped after 4 BUSY cycles, err_o single pulse, rdata_o=0.
//  6 rst asserted in BUSY -> next edge IDLE, bus_req_o=0, stallreq_o=0; later ack ignored.

Source files
------------

// File: rtl/data_bus_if.sv
// data_bus_if: data-side bus interface behind the MEM stage.
// Turns MEM's combinational RAM request into a registered req/ack bus
// transaction. It stalls the pipeline until the bus acknowledges, then
// presents the read data to MEM for one DONE cycle, or longer while stalled.
// Optional feature macro: DBUS_TIMEOUT_EN (abort after TIMEOUT_CYCLES busy
// cycles without ack; err_o pulses). When it is undefined, err_o is tied 0.
module data_bus_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  stallreq_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W/8-1:0]   bus_sel_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              timeout;
  logic [DATA_W-1:0] rdata_q;

  // The low address bits are dropped because the bus is word addressed.
  // This also keeps the timeout parameter referenced in every build.
  logic unused_ok;
  assign unused_ok = ^{addr_i[1:0], TIMEOUT_CYCLES};

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             waiting;
  logic             err_q;

  assign waiting = (state_q == BUSY) || (state_q == ABORT);
  // cnt_q counts the earlier unacked cycles of this BUSY/ABORT stay. If the
  // current cycle is also unacked and is the TIMEOUT_CYCLES-th one, give up.
  assign timeout = waiting && !bus_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;

  // Wait-cycle counter: restarts on every state change and counts only while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_d != state_q || !waiting) cnt_q <= '0;
      else                                cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every register
    // samples the values from before the edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the combinational stall request.
  always_comb begin
    // NOTE: every output gets a default before the case. A path that leaves
    // one unassigned would otherwise infer a latch.
    state_d    = state_q;
    stallreq_o = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_i && !flush_i) begin
          accept     = 1'b1;
          stallreq_o = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        if (bus_ack_i || timeout) state_d = DONE;
        else if (flush_i)         state_d = ABORT;
      end
      ABORT: begin
        // The abandoned access must still finish on the bus. A new request waits.
        stallreq_o = ce_i;
        if (bus_ack_i || timeout) state_d = IDLE;
      end
      DONE: begin
        if (flush_i || !stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus payload, request and read-data capture registers.
  always_ff @(posedge clk) begin
    // NOTE: these are a handful of flops, not a memory array, so they are all
    // reset. The bus then sees defined zeros after rst.
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      rdata_q     <= '0;
    end else begin
      // Request is high exactly while the bus is working on our access.
      bus_req_o <= (state_d == BUSY) || (state_d == ABORT);
      if (accept) begin
        bus_we_o    <= we_i;
        bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        bus_sel_o   <= sel_i;
        bus_wdata_o <= wdata_i;
      end
      // Only an access that completes in BUSY returns data. Writes and
      // timeouts return zero.
      if (state_q == BUSY && (bus_ack_i || timeout)) begin
        rdata_q <= (bus_we_o || timeout) ? '0 : bus_rdata_i;
      end
    end
  end

  assign rdata_o = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_data_bus_if.sv
// Testbench for data_bus_if: directed cycle tables plus randomized traffic
// against a transaction-level reference model. The timeout sequence only
// runs when DBUS_TIMEOUT_EN is defined.
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i, stall_i, flush_i, bus_ack_i;
  logic [31:0] addr_i, wdata_i, bus_rdata_i;
  logic [3:0]  sel_i;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        stallreq_o, bus_req_o, bus_we_o, err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i), .wdata_i(wdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .err_o(err_o)
  );

  // One cycle of stimulus together with the outputs expected in that cycle.
  typedef struct {
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        stall, flush, ack;
    logic [31:0] brdata;
    logic        e_stallreq, e_req, e_err;
    logic [31:0] e_rdata;
    logic        chk_bus, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
  } vec_t;

  function automatic vec_t v_in(input logic ce, we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata,
                                input logic stall, flush, ack, input logic [31:0] brdata);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.stall = stall; v.flush = flush; v.ack = ack; v.brdata = brdata;
    v.e_stallreq = 1'b0; v.e_req = 1'b0; v.e_err = 1'b0; v.e_rdata = '0;
    v.chk_bus = 1'b0; v.e_we = 1'b0; v.e_addr = '0; v.e_wdata = '0; v.e_sel = '0;
    return v;
  endfunction

  function automatic vec_t v_exp(input vec_t v_i, input logic sr, req, input logic [31:0] rd);
    vec_t v = v_i;
    v.e_stallreq = sr; v.e_req = req; v.e_rdata = rd;
    return v;
  endfunction

  function automatic vec_t v_bus(input vec_t v_i, input logic we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] wdata);
    vec_t v = v_i;
    v.chk_bus = 1'b1; v.e_we = we; v.e_addr = addr; v.e_sel = sel; v.e_wdata = wdata;
    return v;
  endfunction

  function automatic vec_t v_err(input vec_t v_i);
    vec_t v = v_i;
    v.e_err = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle from posedge+1, check mid-cycle, then advance to the next posedge+1.
  task automatic run_vec(input vec_t v, input string tag);
    ce_i = v.ce; we_i = v.we; addr_i = v.addr; sel_i = v.sel; wdata_i = v.wdata;
    stall_i = v.stall; flush_i = v.flush; bus_ack_i = v.ack; bus_rdata_i = v.brdata;
    #4;
    check({tag, ".stallreq"}, 32'(stallreq_o), 32'(v.e_stallreq));
    check({tag, ".bus_req"},  32'(bus_req_o),  32'(v.e_req));
    check({tag, ".rdata"},    rdata_o,         v.e_rdata);
    check({tag, ".err"},      32'(err_o),      32'(v.e_err));
    if (v.chk_bus) begin
      check({tag, ".bus_we"},    32'(bus_we_o),  32'(v.e_we));
      check({tag, ".bus_addr"},  bus_addr_o,     v.e_addr);
      check({tag, ".bus_sel"},   32'(bus_sel_o), 32'(v.e_sel));
      check({tag, ".bus_wdata"}, bus_wdata_o,    v.e_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // Reference model state: one outstanding access plus one presented result.
  bit          m_busy, m_abort, m_have;
  logic [31:0] m_res, m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_sel;
  int          m_waits;

  initial begin
    rst = 1'b1;
    ce_i = 0; we_i = 0; addr_i = 0; sel_i = 0; wdata_i = 0;
    stall_i = 0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    @(posedge clk);
    @(posedge clk);
    #4;
    check("reset.bus_req",   32'(bus_req_o),  0);
    check("reset.bus_we",    32'(bus_we_o),   0);
    check("reset.bus_addr",  bus_addr_o,      0);
    check("reset.bus_sel",   32'(bus_sel_o),  0);
    check("reset.bus_wdata", bus_wdata_o,     0);
    check("reset.rdata",     rdata_o,         0);
    check("reset.stallreq",  32'(stallreq_o), 0);
    check("reset.err",       32'(err_o),      0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read with a zero-wait ack, then a write with three wait states.
    tbl.push_back(v_exp(v_in(1, 0, 32'h104, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0));
    tbl.push_back(v_bus(v_exp(v_in(1, 0, 32'h104, 4'hF, 0, 0, 0, 1, 32'hA5A5_1234), 1, 1, 0),
                        0, 32'h104, 4'hF, 0));
    tbl.push_back(v_exp(v_in(1, 0, 32'h104, 4'hF, 0, 0, 0, 0, 0), 0, 0, 32'hA5A5_1234));
    tbl.push_back(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v_exp(v_in(1, 1, 32'h203, 4'h8, 32'h7700_0000, 0, 0, 0, 0), 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v_bus(v_exp(v_in(1, 1, 32'h203, 4'h8, 32'h7700_0000, 0, 0, 0, 0), 1, 1, 0),
                          1, 32'h200, 4'h8, 32'h7700_0000));
    tbl.push_back(v_bus(v_exp(v_in(1, 1, 32'h203, 4'h8, 32'h7700_0000, 0, 0, 1, 32'hDEAD_BEEF), 1, 1, 0),
                        1, 32'h200, 4'h8, 32'h7700_0000));
    tbl.push_back(v_exp(v_in(1, 1, 32'h203, 4'h8, 32'h7700_0000, 0, 0, 0, 0), 0, 0, 0));
    tbl.push_back(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Flush in the 2nd BUSY cycle: ABORT holds req until ack, no data, back to IDLE.
    run_vec(v_exp(v_in(1, 0, 32'h40, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0), "abort0");
    run_vec(v_exp(v_in(1, 0, 32'h40, 4'hF, 0, 0, 0, 0, 0), 1, 1, 0), "abort1");
    run_vec(v_exp(v_in(1, 0, 32'h40, 4'hF, 0, 0, 1, 0, 0), 1, 1, 0), "abort2");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0), "abort3");
    run_vec(v_exp(v_in(1, 0, 32'h44, 4'hF, 0, 0, 0, 1, 32'h1234_5678), 1, 1, 0), "abort4");
    run_vec(v_exp(v_in(1, 0, 32'h44, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0), "abort5");
    run_vec(v_bus(v_exp(v_in(1, 0, 32'h44, 4'hF, 0, 0, 0, 1, 32'h0BAD_F00D), 1, 1, 0),
                  0, 32'h44, 4'hF, 0), "abort6");
    run_vec(v_exp(v_in(1, 0, 32'h44, 4'hF, 0, 0, 0, 0, 0), 0, 0, 32'h0BAD_F00D), "abort7");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "abort8");

    // DONE held by stall_i, then flush out of DONE while still stalled.
    run_vec(v_exp(v_in(1, 0, 32'h80, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0), "hold0");
    run_vec(v_exp(v_in(1, 0, 32'h80, 4'hF, 0, 0, 0, 1, 32'hCAFE_0001), 1, 1, 0), "hold1");
    run_vec(v_exp(v_in(1, 0, 32'h80, 4'hF, 0, 1, 0, 0, 0), 0, 0, 32'hCAFE_0001), "hold2");
    run_vec(v_exp(v_in(1, 0, 32'h80, 4'hF, 0, 1, 0, 0, 0), 0, 0, 32'hCAFE_0001), "hold3");
    run_vec(v_exp(v_in(1, 0, 32'h80, 4'hF, 0, 0, 0, 0, 0), 0, 0, 32'hCAFE_0001), "hold4");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "hold5");
    run_vec(v_exp(v_in(1, 0, 32'h88, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0), "dflush0");
    run_vec(v_exp(v_in(1, 0, 32'h88, 4'hF, 0, 0, 0, 1, 32'h1357_9BDF), 1, 1, 0), "dflush1");
    run_vec(v_exp(v_in(1, 0, 32'h88, 4'hF, 0, 1, 1, 0, 0), 0, 0, 32'h1357_9BDF), "dflush2");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0), "dflush3");

    // Reset in BUSY: next cycle IDLE with cleared bus regs, late ack ignored.
    run_vec(v_exp(v_in(1, 1, 32'h500, 4'h3, 32'h55AA_55AA, 0, 0, 0, 0), 1, 0, 0), "rst0");
    rst = 1'b1;
    run_vec(v_exp(v_in(1, 1, 32'h500, 4'h3, 32'h55AA_55AA, 0, 0, 0, 0), 1, 1, 0), "rst1");
    rst = 1'b0;
    run_vec(v_bus(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000), 0, 0, 0), 0, 0, 0, 0), "rst2");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "rst3");

`ifdef DBUS_TIMEOUT_EN
    // No ack: four BUSY cycles, then DONE with err_o pulse and zero data.
    run_vec(v_exp(v_in(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0), 1, 0, 0), "tmo0");
    for (int i = 1; i <= 4; i++)
      run_vec(v_exp(v_in(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0), 1, 1, 0), $sformatf("tmo%0d", i));
    run_vec(v_err(v_exp(v_in(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0), 0, 0, 0)), "tmo5");
    run_vec(v_exp(v_in(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "tmo6");
`endif

    // Randomized traffic against the transaction-level model.
    m_busy = 0; m_abort = 0; m_have = 0; m_res = 0; m_waits = 0;
    m_addr = 0; m_wdata = 0; m_we = 0; m_sel = 0;
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      logic ce, we, stall, flush, ack, exp_sr;
      logic [31:0] addr, wdata, brdata;
      logic [3:0] sel;
      ce = ($urandom % 4) != 0;
      we = $urandom_range(0, 1) == 1;
      addr = $urandom; wdata = $urandom; brdata = $urandom;
      sel = 4'($urandom_range(0, 15));
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 8) == 0;
      ack = m_busy ? (m_waits >= 2 || ($urandom % 3) == 0) : (($urandom % 4) == 0);
      if (!m_busy && !m_have) exp_sr = ce && !flush;
      else if (m_busy)        exp_sr = m_abort ? ce : 1'b1;
      else                    exp_sr = 1'b0;
      v = v_exp(v_in(ce, we, addr, sel, wdata, stall, flush, ack, brdata),
                exp_sr, m_busy, m_have ? m_res : 32'h0);
      if (m_busy) v = v_bus(v, m_we, m_addr, m_sel, m_wdata);
      run_vec(v, $sformatf("rnd%0d", c));
      if (m_have) begin
        if (flush || !stall) m_have = 0;
      end else if (!m_busy) begin
        if (ce && !flush) begin
          m_busy = 1; m_abort = 0; m_waits = 0;
          m_we = we; m_addr = addr & 32'hFFFF_FFFC; m_sel = sel; m_wdata = wdata;
        end
      end else if (ack) begin
        m_busy = 0;
        if (!m_abort) begin
          m_have = 1;
          m_res = m_we ? 32'h0 : brdata;
        end
      end else begin
        m_waits++;
        if (flush) m_abort = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
